// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family:
// default geometry, read-mode encodings and a constant-evaluable clog2.
package sync_fifo_param_pkg;

    localparam int FIFO_DEF_DATA_W = 8;
    localparam int FIFO_DEF_DEPTH  = 16;

    localparam int FIFO_MODE_REG   = 0;
    localparam int FIFO_MODE_FWFT  = 1;

    // Usable in parameter expressions; returns 0 for value <= 1.
    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_dp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; a reset would force flops instead of RAM,
    // and the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky error flags and selectable first-word-fall-through or registered read.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int  DATA_W = FIFO_DEF_DATA_W,
    parameter int  DEPTH  = FIFO_DEF_DEPTH,
    parameter int  FWFT   = FIFO_MODE_FWFT,
    localparam int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              clr_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // MSB of each pointer is the wrap bit; the low bits address the RAM.
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] ram_rdata;

    assign count        = wptr - rptr;
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    // Thresholds above DEPTH fall out of the plain compares: af never reached, ae always met.
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_accept) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Error flags: a set condition on the same edge beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rd_data  = ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        // rd_valid pulses once per accepted read; rd_data holds between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept;
                if (rd_accept) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: a 16x8 FWFT FIFO and a 8x32 registered-read FIFO.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FWFT instance, DATA_W = 8, DEPTH = 16
    logic       a_rst, a_wr_en, a_rd_en, a_clr_err;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_af_thresh, a_ae_thresh, a_count;

    // Registered-read instance, DATA_W = 32, DEPTH = 8
    logic        b_rst, b_wr_en, b_rd_en, b_clr_err;
    logic [31:0] b_wr_data, b_rd_data;
    logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0]  b_af_thresh, b_ae_thresh, b_count;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_a (
        .clk (clk), .rst (a_rst),
        .wr_en (a_wr_en), .wr_data (a_wr_data),
        .rd_en (a_rd_en), .rd_data (a_rd_data), .rd_valid (a_rd_valid),
        .af_thresh (a_af_thresh), .ae_thresh (a_ae_thresh), .clr_err (a_clr_err),
        .count (a_count), .full (a_full), .empty (a_empty),
        .almost_full (a_af), .almost_empty (a_ae),
        .overflow (a_ovf), .underflow (a_unf)
    );

    sync_fifo_param #(.DATA_W(32), .DEPTH(8), .FWFT(0)) dut_b (
        .clk (clk), .rst (b_rst),
        .wr_en (b_wr_en), .wr_data (b_wr_data),
        .rd_en (b_rd_en), .rd_data (b_rd_data), .rd_valid (b_rd_valid),
        .af_thresh (b_af_thresh), .ae_thresh (b_ae_thresh), .clr_err (b_clr_err),
        .count (b_count), .full (b_full), .empty (b_empty),
        .almost_full (b_af), .almost_empty (b_ae),
        .overflow (b_ovf), .underflow (b_unf)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] wv;
    logic [7:0] rv;

    initial begin
        a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_err = 1'b0; a_wr_data = '0;
        a_af_thresh = 5'd12; a_ae_thresh = 5'd3;
        b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_err = 1'b0; b_wr_data = '0;
        b_af_thresh = 4'd6; b_ae_thresh = 4'd1;
        #3;

        // Reset state
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_count", a_count, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_unf", a_unf, 0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_af", a_af, 0);
        check("rst_ae", a_ae, 1);
        tick();
        a_rst = 1'b0;
        tick();
        check("idle_empty", a_empty, 1);

        // Asynchronous reset mid-burst at count 5
        a_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_wr_data = 8'(8'hA0 + i);
            tick();
        end
        a_wr_en = 1'b0;
        check("burst_count5", a_count, 5);
        #1;
        a_rst = 1'b1;
        #1;
        check("async_rst_count", a_count, 0);
        check("async_rst_empty", a_empty, 1);
        tick();
        a_rst = 1'b0;
        tick();

        // Fill 0x00..0x0F with threshold edges, then one write while full
        a_wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_wr_data = 8'(i);
            tick();
            check("fill_count", a_count, 32'(i + 1));
            if (i == 0) begin
                check("fwft_rd_valid", a_rd_valid, 1);
                check("fwft_empty", a_empty, 0);
                check("fwft_head", a_rd_data, 8'h00);
            end
            if (i + 1 == 3)  check("fill_ae_at3", a_ae, 1);
            if (i + 1 == 4)  check("fill_ae_at4", a_ae, 0);
            if (i + 1 == 11) check("fill_af_at11", a_af, 0);
            if (i + 1 == 12) check("fill_af_at12", a_af, 1);
            if (i + 1 == 15) check("fill_full_at15", a_full, 0);
        end
        check("fill_full", a_full, 1);
        check("fill_ovf_before", a_ovf, 0);
        a_wr_data = 8'hFF;
        tick();
        a_wr_en = 1'b0;
        check("ovf_count", a_count, 16);
        check("ovf_full", a_full, 1);
        check("ovf_set", a_ovf, 1);

        // Drain in order; the refused 0xFF must not appear
        for (int i = 0; i < 16; i++) begin
            check("drain_data", a_rd_data, 32'(i));
            check("drain_count", a_count, 32'(16 - i));
            if (16 - i == 12) check("drain_af_at12", a_af, 1);
            if (16 - i == 11) check("drain_af_at11", a_af, 0);
            if (16 - i == 4)  check("drain_ae_at4", a_ae, 0);
            if (16 - i == 3)  check("drain_ae_at3", a_ae, 1);
            a_rd_en = 1'b1;
            tick();
        end
        a_rd_en = 1'b0;
        check("drain_empty", a_empty, 1);
        check("drain_rd_valid", a_rd_valid, 0);
        check("ovf_sticky", a_ovf, 1);
        tick();
        check("ovf_still_sticky", a_ovf, 1);
        a_clr_err = 1'b1;
        tick();
        a_clr_err = 1'b0;
        check("ovf_cleared", a_ovf, 0);

        // Underflow: set, survives simultaneous clear, then clears
        a_rd_en = 1'b1;
        tick();
        check("unf_set", a_unf, 1);
        check("unf_count", a_count, 0);
        a_clr_err = 1'b1;
        tick();
        check("unf_set_wins", a_unf, 1);
        a_rd_en = 1'b0;
        tick();
        a_clr_err = 1'b0;
        check("unf_cleared", a_unf, 0);

        // Simultaneous read/write at count 8 for 40 cycles across pointer wraps
        wv = 8'h20;
        rv = 8'h20;
        a_wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_wr_data = wv;
            wv++;
            tick();
        end
        check("sim_pre_count", a_count, 8);
        a_rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_wr_data = wv;
            wv++;
            check("sim_data", a_rd_data, 32'(rv));
            rv++;
            tick();
            check("sim_count", a_count, 8);
        end
        a_rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_wr_data = wv;
            wv++;
            tick();
        end
        check("sim_refill_full", a_full, 1);

        // Full with both requests: only the read is accepted
        a_wr_data = 8'hEE;
        a_rd_en = 1'b1;
        check("full_both_head", a_rd_data, 32'(rv));
        rv++;
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        check("full_both_count", a_count, 15);
        check("full_both_ovf", a_ovf, 1);
        a_rd_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("final_drain", a_rd_data, 32'(rv));
            rv++;
            tick();
        end
        a_rd_en = 1'b0;
        check("final_empty", a_empty, 1);

        // Registered-read build
        check("b_rst_rd_valid", b_rd_valid, 0);
        check("b_rst_rd_data", b_rd_data, 0);
        check("b_rst_empty", b_empty, 1);
        check("b_rst_ae", b_ae, 1);
        b_rst = 1'b0;
        tick();
        b_wr_en = 1'b1;
        b_wr_data = 32'hDEADBEEF;
        tick();
        b_wr_en = 1'b0;
        check("b_wr_count", b_count, 1);
        check("b_wr_rd_valid", b_rd_valid, 0);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        check("b_rd_valid_pulse", b_rd_valid, 1);
        check("b_rd_data", b_rd_data, 32'hDEADBEEF);
        check("b_rd_count", b_count, 0);
        tick();
        check("b_rd_valid_drop", b_rd_valid, 0);
        check("b_rd_data_hold", b_rd_data, 32'hDEADBEEF);

        b_wr_en = 1'b1;
        b_wr_data = 32'h11111111;
        tick();
        b_wr_data = 32'h22222222;
        tick();
        b_wr_en = 1'b0;
        b_rd_en = 1'b1;
        tick();
        check("b_b2b_first", b_rd_data, 32'h11111111);
        check("b_b2b_valid1", b_rd_valid, 1);
        tick();
        check("b_b2b_second", b_rd_data, 32'h22222222);
        check("b_b2b_valid2", b_rd_valid, 1);
        tick();
        b_rd_en = 1'b0;
        check("b_empty_rd_valid", b_rd_valid, 0);
        check("b_empty_rd_hold", b_rd_data, 32'h22222222);
        check("b_unf", b_unf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
